// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on magnitudes, fixed WIDTH+1 cycle latency from the start edge.
module multdiv_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [2*WIDTH:0] prod;
   logic [WIDTH-1:0] mcand;
   logic             isDiv;
   logic             negQuot;
   logic             divZero;
   logic             divOvf;

   logic             start;
   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH-1:0] mulAcc;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift;
   logic [WIDTH:0]   divDiff;
   logic [WIDTH-1:0] quotMag;
   logic [WIDTH:0]   prodHigh;

   // Datapath for one iteration. The Booth sum is one bit wider than the
   // accumulator so that subtracting the most negative multiplicand cannot
   // corrupt the sign shifted back in.
   always_comb begin
      start    = ctrl_MULT | ctrl_DIV;
      absA     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      absB     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      mulAcc   = prod[2*WIDTH:WIDTH+1];
      mulSum   = {mulAcc[WIDTH-1], mulAcc};
      case (prod[1:0])
         2'b01:   mulSum = {mulAcc[WIDTH-1], mulAcc} + {mcand[WIDTH-1], mcand};
         2'b10:   mulSum = {mulAcc[WIDTH-1], mulAcc} - {mcand[WIDTH-1], mcand};
         default: mulSum = {mulAcc[WIDTH-1], mulAcc};
      endcase
      divShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      divDiff  = divShift - {1'b0, mcand};
      quotMag  = prod[WIDTH-1:0];
      prodHigh = prod[2*WIDTH:WIDTH];
   end

   // Control and result registers. A start pulse is honoured in every state
   // and is applied last, so it restarts a running operation and still lets
   // a finishing operation deliver its result in the DONE cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         state          <= IDLE;
         count          <= '0;
         prod           <= '0;
         mcand          <= '0;
         isDiv          <= 1'b0;
         negQuot        <= 1'b0;
         divZero        <= 1'b0;
         divOvf         <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            MUL: begin
               prod  <= {mulSum, prod[WIDTH:1]};
               count <= count + CNT_W'(1);
               if (count == CNT_W'(WIDTH-1)) state <= DONE;
            end
            DIV: begin
               if (!divDiff[WIDTH]) prod <= {divDiff, prod[WIDTH-2:0], 1'b1};
               else                 prod <= {divShift, prod[WIDTH-2:0], 1'b0};
               count <= count + CNT_W'(1);
               if (count == CNT_W'(WIDTH-1)) state <= DONE;
            end
            DONE: begin
               if (isDiv) begin
                  if (divZero) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                  end else begin
                     data_result    <= negQuot ? -quotMag : quotMag;
                     data_exception <= divOvf;
                  end
               end else begin
                  data_result    <= prod[WIDTH:1];
                  data_exception <= ~((&prodHigh) | ~(|prodHigh));
               end
               data_resultRDY <= 1'b1;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: ;
         endcase
         if (start) begin
            busy  <= 1'b1;
            count <= '0;
            isDiv <= ~ctrl_MULT;
            if (ctrl_MULT) begin
               state <= MUL;
               prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
               mcand <= data_operandA;
            end else begin
               state   <= DIV;
               prod    <= {{(WIDTH+1){1'b0}}, absA};
               mcand   <= absB;
               negQuot <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               divZero <= (data_operandB == '0);
               divOvf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
            end
         end
      end
   end

endmodule
